// File: rtl/input_event_collector.sv
// Interrupt-driven Avalon-MM reader: on avl_irq, issues one zero-wait read of
// the {keys, switches} byte and queues it (optionally deduplicated) for a consumer.
module input_event_collector #(
  parameter int DEPTH = 16,
  parameter bit DEDUP = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     avl_irq,
  output logic                     avl_read,
  input  logic [7:0]               avl_readdata,
  output logic                     evt_valid,
  output logic [7:0]               evt_data,
  input  logic                     evt_ready,
  output logic [$clog2(DEPTH):0]   evt_count,
  output logic [7:0]               overflow_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, READ, SETTLE} state_t;

  typedef struct packed {
    logic       push;
    logic [7:0] data;
  } cap_t;

  state_t          state;
  logic            have_last;
  logic [7:0]      last_val;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [7:0]      mem [DEPTH];

  cap_t            cap;
  logic            dup, pop, full, wr_en, ovf_inc;

  // avl_read is a registered decode of the next state, so it is high only in READ
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      avl_read <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (avl_irq) begin
            state    <= READ;
            avl_read <= 1'b1;
          end
        end
        READ: begin
          state    <= SETTLE;
          avl_read <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          avl_read <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    dup       = DEDUP && have_last && (avl_readdata == last_val);
    cap.push  = (state == READ) && !dup;
    cap.data  = avl_readdata;
    pop       = evt_valid && evt_ready;
    full      = (evt_count == FULL_CNT);
    // A push into a full FIFO is still accepted when the head leaves on the same edge
    wr_en     = cap.push && (!full || pop);
    ovf_inc   = cap.push && full && !pop;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      have_last <= 1'b0;
      last_val  <= 8'h00;
    end else if (state == READ) begin
      have_last <= 1'b1;
      last_val  <= avl_readdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      evt_count      <= '0;
      overflow_count <= 8'h00;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   evt_count <= evt_count + 1'b1;
        2'b01:   evt_count <= evt_count - 1'b1;
        default: evt_count <= evt_count;
      endcase
      if (ovf_inc && overflow_count != 8'hFF)
        overflow_count <= overflow_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= cap.data;
  end

  assign evt_valid = (evt_count != '0);
  assign evt_data  = mem[rd_ptr];

endmodule

// File: tb/tb_input_event_collector.sv
// Bench for input_event_collector: a DEDUP=1 and a DEDUP=0 instance share the
// device stimulus; each has its own expected-event queue and consumer.
module tb_input_event_collector;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       avl_irq = 1'b0;
  logic [7:0] avl_readdata = 8'h00;

  logic       avl_read1, avl_read0;
  logic       evt_valid1, evt_valid0;
  logic [7:0] evt_data1, evt_data0;
  logic       ready1 = 1'b0, ready0 = 1'b0;
  logic [4:0] count1, count0;
  logic [7:0] ovf1, ovf0;

  input_event_collector #(.DEPTH(16), .DEDUP(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .avl_irq(avl_irq), .avl_read(avl_read1),
    .avl_readdata(avl_readdata), .evt_valid(evt_valid1), .evt_data(evt_data1),
    .evt_ready(ready1), .evt_count(count1), .overflow_count(ovf1));

  input_event_collector #(.DEPTH(16), .DEDUP(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .avl_irq(avl_irq), .avl_read(avl_read0),
    .avl_readdata(avl_readdata), .evt_valid(evt_valid0), .evt_data(evt_data0),
    .evt_ready(ready0), .evt_count(count0), .overflow_count(ovf0));

  always #5 clk = ~clk;

  int   cyc = 0, n_tests = 0, n_fail = 0, nreads = 0, consec = 0;
  int   last_lat, last_cyc;
  logic prev_read = 1'b0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (avl_read1) nreads = nreads + 1;
    if ((avl_read1 && prev_read) || (avl_read1 !== avl_read0)) consec = consec + 1;
    prev_read = avl_read1;
  end

  // expected-event model
  logic [7:0] q1[$], q0[$];
  logic [7:0] last1 = 8'h00;
  bit         have1 = 1'b0;
  int         ovf_m1 = 0, ovf_m0 = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_cap(input logic [7:0] d);
    if (!(have1 && d == last1)) begin
      if (q1.size() == 16) begin
        if (ovf_m1 < 255) ovf_m1++;
      end else q1.push_back(d);
    end
    have1 = 1'b1;
    last1 = d;
    if (q0.size() == 16) begin
      if (ovf_m0 < 255) ovf_m0++;
    end else q0.push_back(d);
  endtask

  // Device side of one read: raise irq, wait for the strobe, optionally pop on the capture edge
  task automatic do_read(input logic [7:0] d, input bit hold, input bit pop);
    int waited = 0;
    avl_readdata = d;
    avl_irq = 1'b1;
    while (!avl_read1 && waited < 8) begin
      tick();
      waited++;
    end
    if (!avl_read1) begin
      chk("read_timeout", 0, 1);
      return;
    end
    last_lat = waited;
    last_cyc = cyc;
    if (!hold) avl_irq = 1'b0;
    if (pop) begin
      chk("pop_valid1", evt_valid1, q1.size() != 0);
      chk("pop_valid0", evt_valid0, q0.size() != 0);
      if (q1.size() != 0) begin chk("pop_head1", evt_data1, q1[0]); void'(q1.pop_front()); end
      if (q0.size() != 0) begin chk("pop_head0", evt_data0, q0[0]); void'(q0.pop_front()); end
      ready1 = 1'b1;
      ready0 = 1'b1;
    end
    model_cap(d);
    tick();
    ready1 = 1'b0;
    ready0 = 1'b0;
  endtask

  task automatic drain(input int w, input int exp_n);
    int n = 0;
    while (n < 40) begin
      logic       v;
      logic [7:0] d, e;
      v = w ? evt_valid1 : evt_valid0;
      if (!v) break;
      d = w ? evt_data1 : evt_data0;
      e = 8'hxx;
      if (w && q1.size() != 0) e = q1.pop_front();
      if (!w && q0.size() != 0) e = q0.pop_front();
      chk(w ? "drain_data1" : "drain_data0", d, e);
      if (w) ready1 = 1'b1; else ready0 = 1'b1;
      tick();
      ready1 = 1'b0;
      ready0 = 1'b0;
      n++;
    end
    chk(w ? "drain_n1" : "drain_n0", n, exp_n);
    chk(w ? "drain_left1" : "drain_left0", w ? q1.size() : q0.size(), 0);
    chk(w ? "drain_cnt1" : "drain_cnt0", w ? count1 : count0, 0);
  endtask

  initial begin
    int c_a, c_b;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_read1", avl_read1, 0);
    chk("rst_valid1", evt_valid1, 0);
    chk("rst_cnt1", count1, 0);
    chk("rst_ovf1", ovf1, 0);
    chk("rst_valid0", evt_valid0, 0);
    chk("rst_cnt0", count0, 0);
    reset_n = 1'b1;
    tick();

    // single event
    do_read(8'hA5, 0, 0);
    chk("single_lat", last_lat, 1);
    chk("single_valid", evt_valid1, 1);
    chk("single_data", evt_data1, 8'hA5);
    chk("single_cnt", count1, 1);
    repeat (4) tick();
    chk("single_nreads", nreads, 1);
    drain(1, 1);
    drain(0, 1);

    // back-to-back with irq held
    do_read(8'h01, 1, 0); c_a = last_cyc;
    do_read(8'h02, 1, 0); c_b = last_cyc;
    chk("b2b_gap1", c_b - c_a, 3);
    do_read(8'h03, 0, 0);
    chk("b2b_gap2", last_cyc - c_b, 3);
    chk("b2b_cnt", count1, 3);
    drain(1, 3);
    drain(0, 3);

    // dedup
    do_read(8'h10, 1, 0);
    do_read(8'h10, 1, 0);
    do_read(8'h11, 0, 0);
    chk("dedup_cnt1", count1, 2);
    chk("dedup_cnt0", count0, 3);
    drain(1, 2);
    drain(0, 3);

    // overflow
    for (int i = 0; i < 20; i++) do_read(8'h20 + 8'(i), i < 19, 0);
    chk("ovf_cnt1", count1, 16);
    chk("ovf_ovf1", ovf1, 4);
    chk("ovf_cnt0", count0, 16);
    chk("ovf_ovf0", ovf0, 4);

    // full with simultaneous pop
    do_read(8'h80, 0, 1);
    chk("fullpop_cnt1", count1, 16);
    chk("fullpop_ovf1", ovf1, 4);
    chk("fullpop_ovf0", ovf0, ovf_m0);
    drain(1, 16);
    chk("drained_valid1", evt_valid1, 0);
    drain(0, 16);

    // overflow counter saturation
    for (int i = 0; i < 272; i++) do_read(8'(i), i < 271, 0);
    chk("sat_ovf1", ovf1, 255);
    chk("sat_ovf0", ovf0, ovf_m0);
    chk("sat_cnt1", count1, 16);

    // async reset during READ
    avl_readdata = 8'h00;
    avl_irq = 1'b1;
    for (int i = 0; i < 8 && !avl_read1; i++) tick();
    chk("rstmid_read_seen", avl_read1, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rstmid_read1", avl_read1, 0);
    chk("rstmid_read0", avl_read0, 0);
    chk("rstmid_valid1", evt_valid1, 0);
    chk("rstmid_cnt1", count1, 0);
    chk("rstmid_ovf1", ovf1, 0);
    chk("rstmid_ovf0", ovf0, 0);
    q1.delete(); q0.delete();
    have1 = 1'b0; last1 = 8'h00; ovf_m1 = 0; ovf_m0 = 0;
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    do_read(8'h00, 1, 0);
    chk("post_rst_lat", last_lat, 1);
    chk("post_rst_cnt1", count1, 1);
    do_read(8'h00, 0, 0);
    chk("post_dedup_cnt1", count1, 1);
    chk("post_dedup_cnt0", count0, 2);
    drain(1, 1);
    drain(0, 2);
    chk("read_pulse_rules", consec, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/input_event_collector.md
# input_event_collector

Avalon-MM master that services the interrupt-driven user input device. When that device raises its IRQ, the collector issues a single-cycle read and captures the 8-bit {keys, switches} snapshot. It queues the snapshot in an event FIFO for a downstream consumer, such as LED/HEX display logic or a soft-CPU shim. It sits between the input device's Avalon slave port and any logic that must see every input change without polling.

## Interface
- DEPTH, 16: FIFO entries; must be a power of two, at least 2.
- DEDUP, 1: when 1, drop a captured value equal to the previously captured value.
- clk  in  1  single clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- avl_irq  in  1  interrupt from the input device; level, held until serviced.
- avl_read  out  1  read strobe to the device.
- avl_readdata  in  8  device read data; valid in the same cycle as avl_read (zero wait states).
- evt_valid  out  1  FIFO head valid.
- evt_data  out  8  FIFO head value.
- evt_ready  in  1  consumer pops the head when evt_valid && evt_ready.
- evt_count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow_count  out  8  count of events dropped because the FIFO was full; saturates at 255.

## Operation
- The FSM has three states: IDLE, READ, SETTLE.
  - IDLE: if avl_irq=1, go to READ.
  - READ: avl_read=1 for exactly this state. Capture avl_readdata at the exiting edge. Go to SETTLE.
  - SETTLE: avl_read=0 for one cycle so the device's IRQ clear becomes visible. Go to IDLE.
- avl_read is registered and decoded only from state READ. It is never high for two consecutive cycles.
- Capture handling, applied at the end of READ:
  - If DEDUP=1 and a previous value has been captured and the new value equals it, do not push.
  - Otherwise push into the FIFO.
  - The "last captured" register always updates to the new value, including when the push is dropped for overflow.
  - The first capture after reset is never deduplicated.
- The FIFO is a circular buffer with DEPTH entries. Read and write pointers wrap modulo DEPTH. Occupancy is tracked by an explicit counter from 0 to DEPTH.
  - evt_valid = (evt_count != 0).
  - evt_data is the head entry, show-ahead; it is defined only while evt_valid=1.
- Push and pop in the same cycle:
  - Both take effect and evt_count is unchanged.
  - This includes the full case: a push while full with a simultaneous pop is accepted and not counted as overflow.
  - In the empty case no pop occurs, because evt_valid=0; the push lands and evt_count becomes 1.
- Push while full with no pop: the data is dropped, overflow_count increments (holding at 255), and the FIFO is unchanged.
- evt_ready while evt_valid=0 has no effect.

## Timing
- Reset values, all applied asynchronously while reset_n=0:
  - State is IDLE.
  - avl_read=0, evt_valid=0, evt_count=0, overflow_count=0.
  - Pointers are 0 and the last-captured register is cleared; "none captured" is tracked with a flag.
- Asserting reset_n mid-READ drops avl_read immediately with no capture. Release is synchronous to the next clk edge.
- Read latency: avl_irq sampled high at edge E0 (state IDLE) produces avl_read=1 in cycle E0–E1. Data is captured at E1, and the pushed entry shows evt_valid=1 after E1 if the FIFO was previously empty.
- Service period: a minimum of 3 cycles per read. If avl_irq is still high after SETTLE, because the device re-raised it, the next READ begins 3 cycles after the previous one.
- A pop at edge E advances the head; the new evt_data and evt_count are visible after E.
- All outputs are registered except evt_valid and evt_data, which are decoded from registered state and FIFO storage.

## Test plan
- Single event: avl_irq rises with readdata=8'hA5, then the device clears it after the read. Required: exactly one avl_read pulse 1 cycle after irq is sampled. After the read edge, evt_valid=1, evt_data=8'hA5 and evt_count=1. Popping returns evt_count=0.
- Back-to-back: avl_irq held high while readdata changes 8'h01, 8'h02, 8'h03 per read, with evt_ready=0. Required: avl_read pulses exactly 3 cycles apart, and the FIFO holds 01, 02, 03 in order with evt_count=3.
- Dedup: DEDUP=1, three reads returning 8'h10, 8'h10, 8'h11. Required: FIFO holds 10, 11. The same sequence with DEDUP=0 yields 10, 10, 11.
- Overflow: DEPTH=16, evt_ready=0, 20 distinct reads. Required: evt_count=16, overflow_count=4, and FIFO contents are the first 16 values. Popping all entries returns them in order and evt_valid drops after the 16th pop.
- Full with simultaneous pop: FIFO full, evt_ready=1 on the cycle of a capture edge. Required: evt_count stays at 16, overflow_count is unchanged, and the new value sits at the tail.
- Async reset mid-read: assert reset_n=0 during the READ cycle. Required: avl_read=0 immediately, and all counters and evt_valid read 0. After release with avl_irq=1, the first read occurs normally.
